// File: rtl/r4_otf_root_converter_pkg.sv
// Shared fpsqrt definitions: converter FSM states and radix-4 one-hot digit encoding.
package r4_otf_root_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions of each signed digit inside the 5-bit one-hot code.
    localparam int unsigned DIG_M2 = 0;
    localparam int unsigned DIG_M1 = 1;
    localparam int unsigned DIG_Z  = 2;
    localparam int unsigned DIG_P1 = 3;
    localparam int unsigned DIG_P2 = 4;

    localparam logic [4:0] CODE_M2 = 5'(1 << DIG_M2);
    localparam logic [4:0] CODE_M1 = 5'(1 << DIG_M1);
    localparam logic [4:0] CODE_Z  = 5'(1 << DIG_Z);
    localparam logic [4:0] CODE_P1 = 5'(1 << DIG_P1);
    localparam logic [4:0] CODE_P2 = 5'(1 << DIG_P2);

endpackage

// File: rtl/r4_otf_root_converter_if.sv
// Handshake and result bundle between the digit-selection datapath and the root converter.
interface r4_otf_root_converter_if #(
    parameter int unsigned Q_W = 27
);
    logic           start_valid_i;
    logic           start_ready_o;
    logic           flush_i;
    logic           dig_valid_i;
    logic [4:0]     dig_i;
    logic           dig_ready_o;
    logic           a0_o;
    logic           a2_o;
    logic           a3_o;
    logic           a4_o;
    logic           res_valid_o;
    logic           res_ready_i;
    logic [Q_W-1:0] root_o;
    logic [Q_W-1:0] root_m1_o;
    logic           err_o;

    modport master (
        output start_valid_i, flush_i, dig_valid_i, dig_i, res_ready_i,
        input  start_ready_o, dig_ready_o, a0_o, a2_o, a3_o, a4_o,
               res_valid_o, root_o, root_m1_o, err_o
    );

    modport slave (
        input  start_valid_i, flush_i, dig_valid_i, dig_i, res_ready_i,
        output start_ready_o, dig_ready_o, a0_o, a2_o, a3_o, a4_o,
               res_valid_o, root_o, root_m1_o, err_o
    );
endinterface

// File: rtl/r4_otf_update.sv
// Combinational on-the-fly conversion step: appends one radix-4 digit to Q and QM at pair position pos.
module r4_otf_update
    import r4_otf_root_converter_pkg::*;
#(
    parameter int unsigned Q_W = 27
) (
    input  logic [Q_W-1:0] q,
    input  logic [Q_W-1:0] qm,
    input  logic [6:0]     pos,
    input  logic [4:0]     dig,
    output logic [Q_W-1:0] q_next,
    output logic [Q_W-1:0] qm_next,
    output logic           bad
);
    logic [Q_W-1:0] one_at;
    logic [Q_W-1:0] two_at;
    logic [Q_W-1:0] three_at;

    always_comb begin
        one_at   = Q_W'(1) << pos;
        two_at   = one_at << 1;
        three_at = one_at | two_at;
        bad      = 1'b0;
        q_next   = q;
        qm_next  = qm | three_at;
        // Negative digits borrow from QM; any non-one-hot code falls through as zero.
        case (dig)
            CODE_P2: begin q_next = q  | two_at;   qm_next = q  | one_at; end
            CODE_P1: begin q_next = q  | one_at;   qm_next = q;           end
            CODE_Z:  begin q_next = q;             qm_next = qm | three_at; end
            CODE_M1: begin q_next = qm | three_at; qm_next = qm | two_at; end
            CODE_M2: begin q_next = qm | two_at;   qm_next = qm | one_at; end
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/r4_otf_root_converter.sv
// Radix-4 on-the-fly root converter: accumulates DIGITS signed digits into Q and Q minus one ulp.
module r4_otf_root_converter
    import r4_otf_root_converter_pkg::*;
#(
    parameter int unsigned DIGITS = 13,
    parameter int unsigned Q_W    = 2 * DIGITS + 1
) (
    input logic                   clk,
    input logic                   rst_n,
    r4_otf_root_converter_if.slave bus
);
    localparam int unsigned    J_W   = $clog2(DIGITS + 1);
    localparam logic [J_W-1:0] LAST  = J_W'(DIGITS - 1);
    localparam logic [Q_W-1:0] Q_ONE = {1'b1, {(Q_W-1){1'b0}}};

    state_t         state;
    logic [Q_W-1:0] q;
    logic [Q_W-1:0] qm;
    logic [Q_W-1:0] q_next;
    logic [Q_W-1:0] qm_next;
    logic [J_W-1:0] j;
    logic [6:0]     pos;
    logic           err;
    logic           digit_bad;
    logic           take_start;

    // Digit j+1 lands at bit pair Q_W-1-2*(j+1).
    assign pos = 7'(Q_W - 3) - 7'({j, 1'b0});

    r4_otf_update #(.Q_W(Q_W)) u_update (
        .q       (q),
        .qm      (qm),
        .pos     (pos),
        .dig     (bus.dig_i),
        .q_next  (q_next),
        .qm_next (qm_next),
        .bad     (digit_bad)
    );

    assign bus.start_ready_o = (state == ST_IDLE) || ((state == ST_DONE) && bus.res_ready_i);
    assign take_start        = bus.start_valid_i && bus.start_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q     <= '0;
            qm    <= '0;
            j     <= '0;
            err   <= 1'b0;
        end else if (bus.flush_i) begin
            state <= ST_IDLE;
            q     <= '0;
            qm    <= '0;
            j     <= '0;
            err   <= 1'b0;
        end else if (take_start) begin
            state <= ST_ITER;
            q     <= Q_ONE;
            qm    <= '0;
            j     <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                ST_ITER: begin
                    if (bus.dig_valid_i) begin
                        q   <= q_next;
                        qm  <= qm_next;
                        j   <= j + 1'b1;
                        err <= err | digit_bad;
                        if (j == LAST) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready_i) state <= ST_IDLE;
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dig_ready_o = (state == ST_ITER);
    assign bus.res_valid_o = (state == ST_DONE);
    assign bus.root_o      = q;
    assign bus.root_m1_o   = qm;
    assign bus.err_o       = err;
    assign bus.a0_o        = q[Q_W-1];
    assign bus.a2_o        = q[Q_W-3];
    assign bus.a3_o        = q[Q_W-4];
    assign bus.a4_o        = q[Q_W-5];
endmodule

// File: tb/tb_r4_otf_root_converter.sv
// Bench for r4_otf_root_converter: directed vectors plus randomized digit streams against an arithmetic root model.
module tb_r4_otf_root_converter;
    localparam int unsigned D  = 3;
    localparam int unsigned QW = 2 * D + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    r4_otf_root_converter_if #(.Q_W(QW)) bus ();

    r4_otf_root_converter #(.DIGITS(D), .Q_W(QW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Signed value of a one-hot digit; anything else counts as zero.
    function automatic int dval(input logic [4:0] c);
        case (c)
            5'b10000: return 2;
            5'b01000: return 1;
            5'b00010: return -1;
            5'b00001: return -2;
            default:  return 0;
        endcase
    endfunction

    function automatic bit dok(input logic [4:0] c);
        return (c == 5'b10000) || (c == 5'b01000) || (c == 5'b00100) ||
               (c == 5'b00010) || (c == 5'b00001);
    endfunction

    // Root after n digits, in units of 4^-D: 1.0 + sum d_k * 4^-k.
    function automatic int model_q(input logic [4:0] cs[D], input int n);
        int v;
        v = 4 ** D;
        for (int k = 0; k < n; k++) v += dval(cs[k]) * (4 ** (D - 1 - k));
        return v;
    endfunction

    function automatic logic [3:0] abits(input int v);
        return {1'((v >> (QW - 1)) & 1), 1'((v >> (QW - 3)) & 1),
                1'((v >> (QW - 4)) & 1), 1'((v >> (QW - 5)) & 1)};
    endfunction

    function automatic logic [4:0] rand_code();
        if ($urandom_range(0, 7) == 0) return 5'($urandom);
        return 5'(1) << $urandom_range(0, 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op();
        bus.start_valid_i = 1'b1;
        step();
        bus.start_valid_i = 1'b0;
    endtask

    task automatic feed(input logic [4:0] c);
        bus.dig_valid_i = 1'b1;
        bus.dig_i       = c;
        step();
        bus.dig_valid_i = 1'b0;
        bus.dig_i       = '0;
    endtask

    task automatic retire();
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [QW-1:0] zero;
        zero = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.start_ready_o !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b want=1", bus.start_ready_o); end
        total++; if (bus.dig_ready_o !== 1'b0) begin bad++; $display("FAIL reset_dig_ready got=%b want=0", bus.dig_ready_o); end
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
        total++; if (bus.root_o !== zero || bus.root_m1_o !== zero) begin bad++; $display("FAIL reset_q got=%b/%b want=0/0", bus.root_o, bus.root_m1_o); end
        total++; if ({bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o} !== 4'b0000) begin bad++; $display("FAIL reset_abits got=%b want=0000", {bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_known();
        // -2, 0, +1
        start_op();
        feed(5'b00001); feed(5'b00100); feed(5'b01000);
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL known1_valid got=%b want=1", bus.res_valid_o); end
        total++; if (bus.root_o !== 7'b0100001) begin bad++; $display("FAIL known1_root got=%b want=0100001", bus.root_o); end
        total++; if (bus.root_m1_o !== 7'b0100000) begin bad++; $display("FAIL known1_m1 got=%b want=0100000", bus.root_m1_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL known1_err got=%b want=0", bus.err_o); end
        retire();
        // +2, +2, +2
        start_op();
        feed(5'b10000);
        total++; if ({bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o} !== 4'b1000) begin bad++; $display("FAIL known2_abits got=%b want=1000", {bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o}); end
        feed(5'b10000); feed(5'b10000);
        total++; if (bus.root_o !== 7'b1101010) begin bad++; $display("FAIL known2_root got=%b want=1101010", bus.root_o); end
        total++; if (bus.root_m1_o !== 7'b1101001) begin bad++; $display("FAIL known2_m1 got=%b want=1101001", bus.root_m1_o); end
        retire();
    endtask

    task automatic test_error();
        logic [4:0] cs[D];
        int m;
        cs[0] = 5'b01000; cs[1] = 5'b00011; cs[2] = 5'b00010;
        start_op();
        feed(cs[0]);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL err_before got=%b want=0", bus.err_o); end
        feed(cs[1]);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err_o); end
        feed(cs[2]);
        m = model_q(cs, D);
        total++; if (bus.root_o !== QW'(m) || bus.root_m1_o !== QW'(m - 1)) begin bad++; $display("FAIL err_root got=%b/%b want=%b/%b", bus.root_o, bus.root_m1_o, QW'(m), QW'(m - 1)); end
        step();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err_o); end
        bus.res_ready_i = 1'b1;
        start_op();
        bus.res_ready_i = 1'b0;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.err_o); end
        for (int k = 0; k < int'(D); k++) feed(5'b00100);
        retire();
    endtask

    task automatic test_hold_restart();
        logic [4:0] cs[D];
        int m;
        for (int k = 0; k < int'(D); k++) cs[k] = 5'(1) << $urandom_range(0, 4);
        m = model_q(cs, D);
        start_op();
        for (int k = 0; k < int'(D); k++) feed(cs[k]);
        for (int c = 0; c < 5; c++) begin
            total++; if (bus.res_valid_o !== 1'b1 || bus.root_o !== QW'(m) || bus.root_m1_o !== QW'(m - 1)) begin
                bad++; $display("FAIL hold_c%0d got=%b %b/%b want=1 %b/%b", c, bus.res_valid_o, bus.root_o, bus.root_m1_o, QW'(m), QW'(m - 1));
            end
            total++; if (bus.start_ready_o !== 1'b0) begin bad++; $display("FAIL hold_start_ready got=%b want=0", bus.start_ready_o); end
            step();
        end
        bus.res_ready_i = 1'b1;
        bus.start_valid_i = 1'b1;
        #1;
        total++; if (bus.start_ready_o !== 1'b1) begin bad++; $display("FAIL restart_ready got=%b want=1", bus.start_ready_o); end
        step();
        bus.res_ready_i = 1'b0;
        bus.start_valid_i = 1'b0;
        total++; if (bus.dig_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL restart_state got=%b%b want=10", bus.dig_ready_o, bus.res_valid_o); end
        total++; if (bus.root_o !== 7'b1000000 || bus.root_m1_o !== 7'b0000000) begin bad++; $display("FAIL restart_q got=%b/%b want=1000000/0000000", bus.root_o, bus.root_m1_o); end
        for (int k = 0; k < int'(D); k++) feed(5'b01000);
        retire();
    endtask

    task automatic test_random();
        logic [4:0] cs[D];
        bit e;
        int m;
        for (int op = 0; op < 40; op++) begin
            for (int k = 0; k < int'(D); k++) cs[k] = rand_code();
            total++; if (bus.start_ready_o !== 1'b1) begin bad++; $display("FAIL rnd%0d_idle got=%b want=1", op, bus.start_ready_o); end
            start_op();
            e = 1'b0;
            for (int k = 0; k < int'(D); k++) begin
                total++; if (bus.dig_ready_o !== 1'b1) begin bad++; $display("FAIL rnd%0d_dig_ready got=%b want=1", op, bus.dig_ready_o); end
                feed(cs[k]);
                e |= !dok(cs[k]);
                m = model_q(cs, k + 1);
                total++; if ({bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o} !== abits(m) || bus.err_o !== e) begin
                    bad++; $display("FAIL rnd%0d_d%0d got=a%b e%b want=a%b e%b", op, k, {bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o}, bus.err_o, abits(m), e);
                end
            end
            m = model_q(cs, D);
            repeat ($urandom_range(0, 3)) step();
            total++; if (bus.res_valid_o !== 1'b1 || bus.root_o !== QW'(m) || bus.root_m1_o !== QW'(m - 1)) begin
                bad++; $display("FAIL rnd%0d_res got=%b %b/%b want=1 %b/%b", op, bus.res_valid_o, bus.root_o, bus.root_m1_o, QW'(m), QW'(m - 1));
            end
            retire();
            total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL rnd%0d_retire got=%b want=0", op, bus.res_valid_o); end
        end
    endtask

    task automatic test_flush();
        start_op();
        feed(5'b10000);
        feed(5'b11000);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL flush_pre_err got=%b want=1", bus.err_o); end
        bus.flush_i = 1'b1;
        bus.dig_valid_i = 1'b1;
        bus.dig_i = 5'b01000;
        bus.start_valid_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.dig_valid_i = 1'b0;
        bus.start_valid_i = 1'b0;
        total++; if (bus.dig_ready_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin bad++; $display("FAIL flush_idle got=%b%b want=01", bus.dig_ready_o, bus.start_ready_o); end
        total++; if (bus.root_o !== 7'b0 || bus.root_m1_o !== 7'b0 || bus.err_o !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b/%b e%b want=0/0 e0", bus.root_o, bus.root_m1_o, bus.err_o); end
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_res c%0d got=%b want=0", c, bus.res_valid_o); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        start_op();
        feed(5'b01000);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.dig_ready_o !== 1'b0 || bus.start_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_hs got=%b%b%b want=010", bus.dig_ready_o, bus.start_ready_o, bus.res_valid_o); end
        total++; if (bus.root_o !== 7'b0 || bus.root_m1_o !== 7'b0 || {bus.a0_o, bus.a2_o, bus.a3_o, bus.a4_o} !== 4'b0) begin bad++; $display("FAIL rstmid_q got=%b/%b want=0/0", bus.root_o, bus.root_m1_o); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        bus.dig_valid_i = 1'b1;
        bus.dig_i = 5'b10000;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (bus.res_valid_o !== 1'b0 || bus.dig_ready_o !== 1'b0) begin bad++; $display("FAIL rstmid_after c%0d got=%b%b want=00", c, bus.res_valid_o, bus.dig_ready_o); end
        end
        bus.dig_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.dig_valid_i   = 1'b0;
        bus.dig_i         = '0;
        bus.res_ready_i   = 1'b0;
        test_reset();
        test_known();
        test_error();
        test_hold_restart();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
